// File: rtl/drum_pkg.sv
// Shared drum-machine types and sizing constants used by the controller and the step player.
package drum_pkg;

    typedef enum logic [1:0] {
        EDIT = 2'd0,
        PLAY = 2'd1,
        RAW  = 2'd2
    } sysmode_t;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } player_state_t;

    localparam int NUM_STEPS  = 8;
    localparam int NUM_VOICES = 4;
    localparam int GATE_W     = 8;

endpackage

// File: rtl/voice_gate.sv
// One voice's gate timer: loads on a trigger, counts down on sample ticks and drives the voice enable.
module voice_gate
    import drum_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              trig,
    input  logic              smpl_tick,
    input  logic [GATE_W-1:0] gate_len,
    output logic              en
);

    logic [GATE_W-1:0] count;
    logic [GATE_W-1:0] count_next;
    logic              reload;
    logic              reload_next;

    // Retriggering a sounding voice first forces one silent cycle, then reloads on the following cycle.
    always_comb begin
        count_next  = count;
        reload_next = 1'b0;
        if (clear) begin
            count_next = '0;
        end else if (trig) begin
            if (count != '0 && gate_len != '0) begin
                count_next  = '0;
                reload_next = 1'b1;
            end else begin
                count_next = gate_len;
            end
        end else if (reload) begin
            count_next = gate_len;
        end else if (smpl_tick && count != '0) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            reload <= 1'b0;
            en     <= 1'b0;
        end else begin
            count  <= count_next;
            reload <= reload_next;
            en     <= (count_next != '0);
        end
    end

endmodule

// File: rtl/step_player.sv
// Pattern step sequencer: walks the 8-step pattern on tempo ticks and gates each voice for gate_len samples.
module step_player
    import drum_pkg::*;
#(
    parameter int NUM_STEPS  = drum_pkg::NUM_STEPS,
    parameter int NUM_VOICES = drum_pkg::NUM_VOICES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   mode,
    input  logic                         step_tick,
    input  logic                         smpl_tick,
    input  logic [NUM_VOICES-1:0]        seq_smpl_1,
    input  logic [NUM_VOICES-1:0]        seq_smpl_2,
    input  logic [NUM_VOICES-1:0]        seq_smpl_3,
    input  logic [NUM_VOICES-1:0]        seq_smpl_4,
    input  logic [NUM_VOICES-1:0]        seq_smpl_5,
    input  logic [NUM_VOICES-1:0]        seq_smpl_6,
    input  logic [NUM_VOICES-1:0]        seq_smpl_7,
    input  logic [NUM_VOICES-1:0]        seq_smpl_8,
    input  logic [GATE_W-1:0]            gate_len,
    output logic [NUM_VOICES-1:0]        voice_en,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic [NUM_STEPS-1:0]         step_onehot,
    output logic                         beat
);

    localparam int                IDX_W     = $clog2(NUM_STEPS);
    localparam logic [IDX_W-1:0]  LAST_STEP = IDX_W'(NUM_STEPS - 1);
    localparam logic [NUM_STEPS-1:0] ONE_HOT0 = {{(NUM_STEPS-1){1'b0}}, 1'b1};

    player_state_t         state;
    logic [NUM_VOICES-1:0] pattern [NUM_STEPS];
    logic [NUM_VOICES-1:0] step_pattern;
    logic [IDX_W-1:0]      next_step;
    logic [IDX_W-1:0]      trig_step;
    logic                  trigger;
    logic                  clear;

    assign pattern[0] = seq_smpl_1;
    assign pattern[1] = seq_smpl_2;
    assign pattern[2] = seq_smpl_3;
    assign pattern[3] = seq_smpl_4;
    assign pattern[4] = seq_smpl_5;
    assign pattern[5] = seq_smpl_6;
    assign pattern[6] = seq_smpl_7;
    assign pattern[7] = seq_smpl_8;

    assign next_step    = (step_idx == LAST_STEP) ? '0 : step_idx + 1'b1;
    assign step_pattern = pattern[trig_step];
    assign step_onehot  = ONE_HOT0 << step_idx;

    // Entering PLAY always triggers step 0; leaving PLAY beats any tick arriving in the same cycle.
    always_comb begin
        trigger   = 1'b0;
        trig_step = '0;
        clear     = 1'b0;
        case (state)
            STOP: begin
                if (mode == PLAY) begin
                    trigger = 1'b1;
                end
            end
            RUN: begin
                if (mode != PLAY) begin
                    clear = 1'b1;
                end else if (step_tick) begin
                    trigger   = 1'b1;
                    trig_step = next_step;
                end
            end
            default: clear = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= STOP;
            step_idx <= '0;
            beat     <= 1'b0;
        end else begin
            beat <= trigger && (trig_step == '0);
            case (state)
                STOP: begin
                    step_idx <= '0;
                    if (mode == PLAY) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (mode != PLAY) begin
                        state    <= STOP;
                        step_idx <= '0;
                    end else if (step_tick) begin
                        step_idx <= trig_step;
                    end
                end
                default: begin
                    state    <= STOP;
                    step_idx <= '0;
                end
            endcase
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        voice_gate u_gate (
            .clk       (clk),
            .rst       (rst),
            .clear     (clear),
            .trig      (trigger & step_pattern[v]),
            .smpl_tick (smpl_tick),
            .gate_len  (gate_len),
            .en        (voice_en[v])
        );
    end

endmodule

// File: tb/tb_step_player.sv
// Self-checking bench for step_player: cycle-by-cycle behavioural model plus directed literal checks.
module tb_step_player;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'd0;
    logic       step_tick = 1'b0;
    logic       smpl_tick = 1'b0;
    logic [7:0] gate_len = 8'd3;
    logic [3:0] pat [8];
    logic [3:0] voice_en;
    logic [2:0] step_idx;
    logic [7:0] step_onehot;
    logic       beat;

    int checkCount = 0;
    int passCount  = 0;

    // Model state: notes left per voice in sample ticks, and voices owed a reload after a silent gap.
    bit  modelValid = 1'b0;
    bit  mRun  = 1'b0;
    int  mIdx  = 0;
    bit  mBeat = 1'b0;
    int  mRemain [4];
    bit  mGap [4];

    always #5 clk = ~clk;

    step_player dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .step_tick   (step_tick),
        .smpl_tick   (smpl_tick),
        .seq_smpl_1  (pat[0]),
        .seq_smpl_2  (pat[1]),
        .seq_smpl_3  (pat[2]),
        .seq_smpl_4  (pat[3]),
        .seq_smpl_5  (pat[4]),
        .seq_smpl_6  (pat[5]),
        .seq_smpl_7  (pat[6]),
        .seq_smpl_8  (pat[7]),
        .gate_len    (gate_len),
        .voice_en    (voice_en),
        .step_idx    (step_idx),
        .step_onehot (step_onehot),
        .beat        (beat)
    );

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic st, input logic sm);
        mode      = m;
        step_tick = st;
        smpl_tick = sm;
        @(posedge clk);
        #1;
        step_tick = 1'b0;
        smpl_tick = 1'b0;
    endtask

    function automatic logic [3:0] modelEn();
        logic [3:0] e;
        e = '0;
        for (int v = 0; v < 4; v++) begin
            e[v] = (mRemain[v] > 0);
        end
        return e;
    endfunction

    // A triggered voice sounds for gate_len sample ticks; a still-sounding voice pays one silent cycle first.
    task automatic modelTrigger(input int s);
        logic [3:0] p;
        p = pat[s];
        for (int v = 0; v < 4; v++) begin
            if (p[v]) begin
                if (mRemain[v] > 0 && gate_len != 0) begin
                    mRemain[v] = 0;
                    mGap[v]    = 1'b1;
                end else begin
                    mRemain[v] = int'(gate_len);
                    mGap[v]    = 1'b0;
                end
            end else if (mGap[v]) begin
                mRemain[v] = int'(gate_len);
                mGap[v]    = 1'b0;
            end else if (smpl_tick && mRemain[v] > 0) begin
                mRemain[v] = mRemain[v] - 1;
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mRun = 1'b0;
            mIdx = 0;
            mBeat = 1'b0;
            for (int v = 0; v < 4; v++) begin
                mRemain[v] = 0;
                mGap[v] = 1'b0;
            end
            modelValid = 1'b1;
        end else if (!mRun) begin
            mBeat = 1'b0;
            if (mode == 2'd1) begin
                mRun = 1'b1;
                mIdx = 0;
                mBeat = 1'b1;
                for (int v = 0; v < 4; v++) begin
                    if (pat[0][v]) mRemain[v] = int'(gate_len);
                end
            end
        end else if (mode != 2'd1) begin
            mRun = 1'b0;
            mIdx = 0;
            mBeat = 1'b0;
            for (int v = 0; v < 4; v++) begin
                mRemain[v] = 0;
                mGap[v] = 1'b0;
            end
        end else if (step_tick) begin
            mIdx = (mIdx + 1) % 8;
            mBeat = (mIdx == 0);
            modelTrigger(mIdx);
        end else begin
            mBeat = 1'b0;
            for (int v = 0; v < 4; v++) begin
                if (mGap[v]) begin
                    mRemain[v] = int'(gate_len);
                    mGap[v] = 1'b0;
                end else if (smpl_tick && mRemain[v] > 0) begin
                    mRemain[v] = mRemain[v] - 1;
                end
            end
        end
    end

    // Every cycle after the first reset edge, all outputs must agree with the model.
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("cyc_step_idx", 8'(step_idx), 8'(mIdx));
            checkOutput("cyc_onehot", step_onehot, 8'(1 << mIdx));
            checkOutput("cyc_beat", 8'(beat), 8'(mBeat));
            checkOutput("cyc_voice_en", 8'(voice_en), 8'(modelEn()));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        pat[0] = 4'b0001;
        pat[1] = 4'b0010;
        pat[2] = 4'b0010;
        for (int s = 3; s < 8; s++) pat[s] = 4'b0000;

        // Reset state
        applyStimulus(2'd0, 1'b0, 1'b0);
        applyStimulus(2'd0, 1'b1, 1'b1);
        checkOutput("rst_step_idx", 8'(step_idx), 8'd0);
        checkOutput("rst_onehot", step_onehot, 8'h01);
        checkOutput("rst_beat", 8'(beat), 8'd0);
        checkOutput("rst_voice_en", 8'(voice_en), 8'd0);
        rst = 1'b0;
        applyStimulus(2'd0, 1'b1, 1'b1);
        checkOutput("edit_ignores_tick", 8'(step_idx), 8'd0);

        // Entry trigger; the simultaneous step_tick is ignored
        applyStimulus(2'd1, 1'b1, 1'b0);
        checkOutput("entry_step_idx", 8'(step_idx), 8'd0);
        checkOutput("entry_beat", 8'(beat), 8'd1);
        checkOutput("entry_voice_en", 8'(voice_en), 8'h01);
        applyStimulus(2'd1, 1'b0, 1'b1);
        checkOutput("entry_beat_drop", 8'(beat), 8'd0);
        applyStimulus(2'd1, 1'b0, 1'b1);
        checkOutput("entry_gate_2ticks", 8'(voice_en), 8'h01);
        applyStimulus(2'd1, 1'b0, 1'b1);
        checkOutput("entry_gate_3ticks", 8'(voice_en), 8'h00);

        // Wrap walk 1..7,0
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(2'd1, 1'b1, 1'b0);
            checkOutput("wrap_step_idx", 8'(step_idx), 8'(i % 8));
            checkOutput("wrap_onehot", step_onehot, 8'(1 << (i % 8)));
            checkOutput("wrap_beat", 8'(beat), (i == 8) ? 8'd1 : 8'd0);
        end

        // Retrigger gap on voice 1
        gate_len = 8'd200;
        applyStimulus(2'd0, 1'b0, 1'b0);
        applyStimulus(2'd1, 1'b0, 1'b0);
        checkOutput("retrig_entry_en", 8'(voice_en), 8'h01);
        applyStimulus(2'd1, 1'b1, 1'b0);
        checkOutput("retrig_first_en", 8'(voice_en), 8'h03);
        applyStimulus(2'd1, 1'b0, 1'b1);
        applyStimulus(2'd1, 1'b0, 1'b1);
        applyStimulus(2'd1, 1'b1, 1'b0);
        checkOutput("retrig_step_idx", 8'(step_idx), 8'd2);
        checkOutput("retrig_gap_en", 8'(voice_en), 8'h01);
        applyStimulus(2'd1, 1'b0, 1'b1);
        checkOutput("retrig_back_en", 8'(voice_en), 8'h03);
        applyStimulus(2'd1, 1'b0, 1'b0);
        checkOutput("retrig_hold_en", 8'(voice_en), 8'h03);

        // Stop wins over a simultaneous step_tick
        applyStimulus(2'd0, 1'b1, 1'b0);
        checkOutput("simul_step_idx", 8'(step_idx), 8'd0);
        checkOutput("simul_voice_en", 8'(voice_en), 8'h00);
        checkOutput("simul_beat", 8'(beat), 8'd0);

        // gate_len 0 never sounds a voice
        gate_len = 8'd0;
        for (int s = 0; s < 8; s++) pat[s] = 4'b1111;
        applyStimulus(2'd1, 1'b0, 1'b0);
        checkOutput("gl0_entry_beat", 8'(beat), 8'd1);
        checkOutput("gl0_entry_en", 8'(voice_en), 8'h00);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(2'd1, 1'b1, 1'b1);
            checkOutput("gl0_step_en", 8'(voice_en), 8'h00);
        end

        // Reset mid-gate, then re-entry
        gate_len = 8'd50;
        applyStimulus(2'd0, 1'b0, 1'b0);
        applyStimulus(2'd1, 1'b0, 1'b0);
        checkOutput("mid_gate_en", 8'(voice_en), 8'h0F);
        applyStimulus(2'd1, 1'b1, 1'b1);
        rst = 1'b1;
        applyStimulus(2'd1, 1'b1, 1'b1);
        checkOutput("midrst_step_idx", 8'(step_idx), 8'd0);
        checkOutput("midrst_onehot", step_onehot, 8'h01);
        checkOutput("midrst_beat", 8'(beat), 8'd0);
        checkOutput("midrst_voice_en", 8'(voice_en), 8'h00);
        rst = 1'b0;
        applyStimulus(2'd1, 1'b0, 1'b0);
        checkOutput("reentry_step_idx", 8'(step_idx), 8'd0);
        checkOutput("reentry_beat", 8'(beat), 8'd1);
        checkOutput("reentry_voice_en", 8'(voice_en), 8'h0F);
        applyStimulus(2'd1, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/step_player.md
STEP_PLAYER -- requirements
Module: step_player

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have parameter NUM_STEPS, default 8, number of pattern steps (fixed at 8 in this design).
REQ-003 The block SHALL have parameter NUM_VOICES, default 4, number of voices per step.
REQ-004 The block SHALL have port clk  input  1  system clock.
REQ-005 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 The block SHALL have port mode  input  2  system mode from the controller (0 EDIT, 1 PLAY, 2 RAW).
REQ-007 The block SHALL have port step_tick  input  1  one-cycle tempo pulse; each pulse advances one step.
REQ-008 The block SHALL have port smpl_tick  input  1  one-cycle sample-rate pulse; it times gate countdown.
REQ-009 The block SHALL have ports seq_smpl_1..seq_smpl_8  input  4 each  per-step voice pattern from sequence_editor; bit v set means voice v plays on that step.
REQ-010 The block SHALL have port gate_len  input  8  gate length in smpl_tick units.
REQ-011 The block SHALL have port voice_en  output  4  per-voice enable to sample instances.
REQ-012 The block SHALL have port step_idx  output  3  current step index.
REQ-013 The block SHALL have port step_onehot  output  8  one-hot of step_idx, for LEDs.
REQ-014 The block SHALL have port beat  output  1  one-cycle pulse when step 0 triggers.

Function
REQ-015 The FSM SHALL have states STOP and RUN; STOP->RUN when mode==PLAY; RUN->STOP when mode!=PLAY.
REQ-016 On the STOP->RUN transition cycle N, step 0 SHALL trigger with step_idx=0 registered at N+1; a step_tick in cycle N is ignored.
REQ-017 In RUN, step_tick at cycle N SHALL set step_idx=(step_idx+1) mod 8 at N+1 and trigger that step; step 7 wraps to 0.
REQ-018 A trigger SHALL sample the pattern for the new step in cycle N; for each set bit v, voice v's gate counter loads gate_len.
REQ-019 voice_en[v] SHALL be registered and equal (gate counter v != 0).
REQ-020 Gate counters SHALL decrement by 1 on smpl_tick, saturating at 0; a load in the same cycle as smpl_tick takes priority.
REQ-021 Retrigger: if voice v is active when it is triggered at cycle N, voice_en[v] SHALL be 0 for exactly cycle N+1 and 1 from N+2; the load occurs at N+1.
REQ-022 A first trigger of an idle voice SHALL assert voice_en[v] at N+1.
REQ-023 gate_len==0 SHALL produce no assertion of voice_en[v], including no retrigger gap.
REQ-024 Voices whose bit is clear on a trigger SHALL keep counting down unaffected.
REQ-025 Pattern changes between triggers SHALL have no effect until the next trigger.
REQ-026 On RUN->STOP at cycle N, all gate counters SHALL clear, with voice_en=0 and step_idx=0 at N+1; mode change wins over a simultaneous step_tick.
REQ-027 In STOP, step_tick and smpl_tick SHALL be ignored and all outputs held at reset values.
REQ-028 beat SHALL be high for the one cycle N+1 after any trigger of step 0, including the entry trigger.
REQ-029 step_onehot SHALL equal 1<<step_idx at all times.

Reset
REQ-030 On rst, the state SHALL be STOP, with voice_en=0, step_idx=0, step_onehot=8'h01, beat=0 and all gate counters 0.
REQ-031 rst asserted mid-RUN SHALL dominate all inputs; after release, the first trigger SHALL be the entry trigger of REQ-016 if mode==PLAY.

Structure
REQ-032 Shared package drum_pkg SHALL hold sysmode_t {EDIT=0, PLAY=1, RAW=2} plus NUM_STEPS and NUM_VOICES; controller and step_player both import it.
REQ-033 Sub-module voice_gate (8-bit counter, load/retrigger-gap logic, en output) SHALL be instantiated NUM_VOICES times.

Verification
REQ-034 Entry test: with gate_len=3, pattern step0=4'b0001 and mode 0->1 at cycle N, the bench SHALL see step_idx=0, beat=1 and voice_en=0001 at N+1, and voice_en=0000 after 3 smpl_ticks.
REQ-035 Wrap test: in RUN, 8 step_ticks SHALL walk step_idx 1..7,0, with beat=1 only after the eighth tick and step_onehot tracking.
REQ-036 Retrigger test: with gate_len=200 and step1 and step2 both 4'b0010, a second tick while voice 1 is active SHALL give voice_en[1]=0 for exactly one cycle, then 1.
REQ-037 Simultaneous test: step_tick and mode 1->0 in the same cycle SHALL give step_idx=0 and voice_en=0 next cycle, with no beat.
REQ-038 gate_len=0 test: a full pattern 4'b1111 SHALL never assert voice_en over 8 steps.
REQ-039 Reset test: rst mid-gate with voice_en=1111 SHALL give all outputs at reset values next cycle; after release with mode==PLAY, the entry trigger of step 0 SHALL occur.
